maria_bus_arb: RTL and testbench



---
 rtl/maria_pkg.sv | 26 ++
 rtl/maria_bus_arb.sv | 186 ++++++++++++++++++
 tb/tb_maria_bus_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maria_pkg.sv
// -----------------------------------------------------------------------------
// maria_pkg
// Shared types and constants for the Maria system-bus logic.
//   arb_state_t    : bus arbiter state encoding
//   ARB_WDOG_TICKS : consecutive idle DMA ticks tolerated while the DMA owns
//                    the bus before the grant is forcibly withdrawn
// -----------------------------------------------------------------------------
package maria_pkg;

  typedef enum logic [2:0] {
    ARB_CPU,
    ARB_HALT_WAIT,
    ARB_HALT_SYNC,
    ARB_DMA,
    ARB_TURN
  } arb_state_t;

  localparam int ARB_WDOG_TICKS = 16;
  localparam int ARB_WDOG_W     = $clog2(ARB_WDOG_TICKS + 1);

  // Count value on the tick that completes the idle run.
  localparam logic [ARB_WDOG_W-1:0] ARB_WDOG_LAST = ARB_WDOG_W'(ARB_WDOG_TICKS - 1);

  localparam logic [7:0] STEAL_MAX = 8'hFF;

endpackage

// File: rtl/maria_bus_arb.sv
// -----------------------------------------------------------------------------
// maria_bus_arb
// Shares the 7800 system bus between the 6502 CPU and the Maria DMA engine.
// A DMA halt request pulls the CPU RDY line low, then the address bus is handed
// to the DMA only once the CPU is parked on a read cycle (the 6502 ignores RDY
// during writes). The grant is released through a one-tick turnaround, a
// watchdog withdraws the grant from a DMA that stops driving addresses, and the
// number of halted ticks per scanline is reported for debug.
//
// Ports
//   clk_sys   in   system clock
//   reset     in   synchronous, active-high reset
//   mclk0     in   Maria tick enable; state only advances when high
//   pclk1     in   CPU phi2 falling-edge strobe (coincident with mclk0)
//   hbs       in   line-start strobe
//   dma_halt  in   DMA halt request (level)
//   dma_drive in   DMA drives dma_addr this tick
//   dma_addr  in   DMA address
//   cpu_addr  in   CPU address
//   cpu_rw    in   CPU direction, 1 = read
//   cpu_dout  in   CPU write data
//   halt_n    out  CPU RDY, 0 = stop CPU
//   bus_grant out  1 = DMA owns the bus
//   bus_addr  out  muxed bus address
//   bus_rw    out  muxed bus direction
//   bus_dout  out  muxed write data
//   bus_err   out  sticky watchdog flag
//   steal_cnt out  halted ticks counted over the previous line
// -----------------------------------------------------------------------------
module maria_bus_arb
  import maria_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mclk0,
  input  logic        pclk1,
  input  logic        hbs,
  input  logic        dma_halt,
  input  logic        dma_drive,
  input  logic [15:0] dma_addr,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  output logic        halt_n,
  output logic        bus_grant,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_dout,
  output logic        bus_err,
  output logic [7:0]  steal_cnt
);

  arb_state_t              r_state;
  logic                    r_halt_n;
  logic                    r_bus_grant;
  logic                    r_bus_err;
  logic                    r_lockout;
  logic [15:0]             r_dma_addr_hold;
  logic [ARB_WDOG_W-1:0]   r_wdog_cnt;
  logic [7:0]              r_steal_run;
  logic [7:0]              r_steal_cnt;

  logic [15:0]             w_dma_addr;

  // ---------------------------------------------------------------------------
  // Arbitration FSM, all outputs registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state         <= ARB_CPU;
      r_halt_n        <= 1'b1;
      r_bus_grant     <= 1'b0;
      r_bus_err       <= 1'b0;
      r_lockout       <= 1'b0;
      r_dma_addr_hold <= 16'h0000;
      r_wdog_cnt      <= '0;
    end else if (mclk0) begin
      // A watchdog lockout only lifts once the DMA has let go of its request,
      // so a hung engine holding dma_halt high cannot immediately re-halt.
      if (!dma_halt) begin
        r_lockout <= 1'b0;
      end

      unique case (r_state)
        ARB_CPU: begin
          r_halt_n <= 1'b1;
          if (dma_halt && !r_lockout) begin
            r_halt_n <= 1'b0;
            r_state  <= ARB_HALT_WAIT;
          end
        end

        ARB_HALT_WAIT: begin
          // Abort takes priority over a coincident pclk1.
          if (!dma_halt) begin
            r_halt_n <= 1'b1;
            r_state  <= ARB_CPU;
          end else if (pclk1) begin
            r_state <= ARB_HALT_SYNC;
          end
        end

        ARB_HALT_SYNC: begin
          // The CPU only honours RDY on reads, so pending writes keep us here.
          if (!dma_halt) begin
            r_halt_n <= 1'b1;
            r_state  <= ARB_CPU;
          end else if (pclk1 && cpu_rw) begin
            r_bus_grant <= 1'b1;
            r_wdog_cnt  <= '0;
            r_state     <= ARB_DMA;
          end
        end

        ARB_DMA: begin
          if (dma_drive) begin
            r_dma_addr_hold <= dma_addr;
            r_wdog_cnt      <= '0;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
          end

          if (!dma_halt) begin
            r_bus_grant <= 1'b0;
            r_state     <= ARB_TURN;
          end else if (!dma_drive && (r_wdog_cnt == ARB_WDOG_LAST)) begin
            r_bus_grant <= 1'b0;
            r_bus_err   <= 1'b1;
            r_lockout   <= 1'b1;
            r_state     <= ARB_TURN;
          end
        end

        ARB_TURN: begin
          r_halt_n <= 1'b1;
          r_state  <= ARB_CPU;
        end

        default: begin
          r_halt_n    <= 1'b1;
          r_bus_grant <= 1'b0;
          r_state     <= ARB_CPU;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stolen-cycle counter. The hbs tick itself belongs to the new line.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_steal_run <= 8'd0;
      r_steal_cnt <= 8'd0;
    end else if (mclk0) begin
      if (hbs) begin
        r_steal_cnt <= r_steal_run;
        r_steal_run <= r_halt_n ? 8'd0 : 8'd1;
      end else if (!r_halt_n && (r_steal_run != STEAL_MAX)) begin
        r_steal_run <= r_steal_run + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus mux, driven from the registered grant. A driving DMA passes its
  // address straight through; otherwise the last driven address is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_dma_addr = dma_drive ? dma_addr : r_dma_addr_hold;
    bus_addr   = cpu_addr;
    bus_rw     = cpu_rw;
    bus_dout   = cpu_dout;
    if (r_bus_grant) begin
      bus_addr = w_dma_addr;
      bus_rw   = 1'b1;
      bus_dout = 8'h00;
    end
  end

  assign halt_n    = r_halt_n;
  assign bus_grant = r_bus_grant;
  assign bus_err   = r_bus_err;
  assign steal_cnt = r_steal_cnt;

endmodule

// File: tb/tb_maria_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_maria_bus_arb
// Directed bench for maria_bus_arb. Each call to tick() covers one Maria tick:
// inputs set before the call are sampled at the following clk_sys edge and
// outputs are observed 1 time unit after that edge. pclk1 is generated from
// the local tick index (every 4 ticks, phase 2) when pclk_en is set.
// -----------------------------------------------------------------------------
module tb_maria_bus_arb;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        mclk0;
  logic        pclk1;
  logic        hbs;
  logic        dma_halt;
  logic        dma_drive;
  logic [15:0] dma_addr;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic        halt_n;
  logic        bus_grant;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_dout;
  logic        bus_err;
  logic [7:0]  steal_cnt;

  int checks   = 0;
  int failures = 0;
  int tk       = 0;
  bit pclk_en  = 1'b0;

  maria_bus_arb dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .mclk0     (mclk0),
    .pclk1     (pclk1),
    .hbs       (hbs),
    .dma_halt  (dma_halt),
    .dma_drive (dma_drive),
    .dma_addr  (dma_addr),
    .cpu_addr  (cpu_addr),
    .cpu_rw    (cpu_rw),
    .cpu_dout  (cpu_dout),
    .halt_n    (halt_n),
    .bus_grant (bus_grant),
    .bus_addr  (bus_addr),
    .bus_rw    (bus_rw),
    .bus_dout  (bus_dout),
    .bus_err   (bus_err),
    .steal_cnt (steal_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    pclk1 = pclk_en && ((tk % 4) == 2);
    @(posedge clk_sys);
    #1;
    tk++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %-16s tick=%0d observed=%0h expected=%0h ok", tag, tk, obs, exp);
    end else begin
      failures++;
      $error("FAIL %s tick=%0d observed=%0h expected=%0h", tag, tk, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mclk0     = 1'b1;
    pclk1     = 1'b0;
    hbs       = 1'b0;
    dma_halt  = 1'b0;
    dma_drive = 1'b0;
    dma_addr  = 16'h0000;
    cpu_addr  = 16'h1234;
    cpu_rw    = 1'b1;
    cpu_dout  = 8'h5A;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_halt_n", halt_n, 1);
    chk("rst_grant", bus_grant, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_steal", steal_cnt, 0);
    chk("rst_addr", bus_addr, 16'h1234);
    chk("rst_dout", bus_dout, 8'h5A);

    // No state advance while mclk0 is low
    mclk0    = 1'b0;
    dma_halt = 1'b1;
    tick();
    tick();
    tick();
    chk("gate_halt_n", halt_n, 1);
    dma_halt = 1'b0;
    mclk0    = 1'b1;
    tick();

    // A: request with CPU reading; grant after second pclk1 (tick 6)
    tk        = 0;
    pclk_en   = 1'b1;
    cpu_rw    = 1'b1;
    dma_addr  = 16'h1F84;
    dma_drive = 1'b1;
    dma_halt  = 1'b1;
    tick();
    chk("A_halt_n_t1", halt_n, 0);
    chk("A_grant_t1", bus_grant, 0);
    while (tk < 6) tick();
    chk("A_grant_t6", bus_grant, 0);
    chk("A_addr_t6", bus_addr, 16'h1234);
    tick();
    chk("A_grant_t7", bus_grant, 1);
    chk("A_addr_t7", bus_addr, 16'h1F84);
    chk("A_rw_t7", bus_rw, 1);
    chk("A_dout_t7", bus_dout, 0);
    tick();
    // Held address survives the DMA releasing the address lines
    dma_drive = 1'b0;
    dma_addr  = 16'hBEEF;
    dma_halt  = 1'b0;
    #1;
    chk("A_held_addr", bus_addr, 16'h1F84);
    tick();
    chk("A_turn_grant", bus_grant, 0);
    chk("A_turn_halt_n", halt_n, 0);
    tick();
    chk("A_rel_halt_n", halt_n, 1);

    // B: two pending writes delay the grant by 8 ticks, then watchdog
    tk        = 0;
    cpu_rw    = 1'b0;
    cpu_addr  = 16'h2345;
    dma_drive = 1'b1;
    dma_addr  = 16'h1F84;
    dma_halt  = 1'b1;
    while (tk < 14) begin
      tick();
      if (tk == 7 || tk == 11) begin
        chk("B_grant_wr", bus_grant, 0);
        chk("B_addr_wr", bus_addr, 16'h2345);
      end
    end
    cpu_rw    = 1'b1;
    dma_drive = 1'b0;
    dma_addr  = 16'h0BAD;
    tick();
    chk("B_grant_t15", bus_grant, 1);
    chk("B_addr_held", bus_addr, 16'h1F84);
    while (tk < 30) tick();
    chk("B_wdog_15_err", bus_err, 0);
    chk("B_wdog_15_gnt", bus_grant, 1);
    tick();
    chk("B_wdog_err", bus_err, 1);
    chk("B_wdog_grant", bus_grant, 0);
    chk("B_wdog_halt0", halt_n, 0);
    tick();
    chk("B_wdog_halt_n", halt_n, 1);
    tick();
    tick();
    chk("B_lockout", halt_n, 1);
    dma_halt = 1'b0;
    tick();
    dma_halt = 1'b1;
    tick();
    chk("B_rehalt", halt_n, 0);
    // Abort out of HALT_WAIT
    dma_halt = 1'b0;
    tick();
    chk("B_abort_halt_n", halt_n, 1);
    chk("B_abort_grant", bus_grant, 0);
    chk("B_err_sticky", bus_err, 1);

    // C: abort in HALT_SYNC coincident with a read pclk1; abort wins
    tk       = 0;
    cpu_rw   = 1'b1;
    dma_halt = 1'b1;
    while (tk < 6) tick();
    dma_halt = 1'b0;
    tick();
    chk("C_abort_grant", bus_grant, 0);
    chk("C_abort_halt_n", halt_n, 1);

    // D: stolen-cycle counter, then saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("D_rst_err", bus_err, 0);
    pclk_en  = 1'b0;
    hbs      = 1'b1;
    dma_halt = 1'b1;
    tick();
    hbs = 1'b0;
    chk("D_steal_0", steal_cnt, 0);
    chk("D_halt_n", halt_n, 0);
    repeat (40) tick();
    hbs = 1'b1;
    tick();
    hbs = 1'b0;
    chk("D_steal_40", steal_cnt, 40);
    repeat (300) tick();
    hbs = 1'b1;
    tick();
    hbs = 1'b0;
    chk("D_steal_255", steal_cnt, 255);
    dma_halt = 1'b0;
    tick();

    // E: reset while the DMA owns the bus
    tk        = 0;
    pclk_en   = 1'b1;
    cpu_rw    = 1'b1;
    cpu_addr  = 16'h3456;
    dma_drive = 1'b1;
    dma_addr  = 16'h1F84;
    dma_halt  = 1'b1;
    while (tk < 8) tick();
    chk("E_grant", bus_grant, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("E_halt_n", halt_n, 1);
    chk("E_grant_clr", bus_grant, 0);
    chk("E_err", bus_err, 0);
    chk("E_steal", steal_cnt, 0);
    chk("E_addr", bus_addr, 16'h3456);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
